// File: rtl/bisr_pkg.sv
// Shared types and defaults for the BISR remap register.
package bisr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int unsigned AW_DEF      = 16;
    localparam int unsigned BLK_LSB_DEF = 4;
    localparam int unsigned NSPARE_DEF  = 4;

    function automatic int unsigned tag_w(input int unsigned aw, input int unsigned blk_lsb);
        return aw - blk_lsb;
    endfunction

endpackage

// File: rtl/bisr_cam.sv
// Remap entry storage with parallel compare for dedupe and lookup; lowest index wins.
// BISR_PARITY_EN adds an even-parity bit per entry and a parity check on the lookup match.
module bisr_cam #(
    parameter int unsigned TW     = 12,
    parameter int unsigned NSPARE = 4,
    localparam int unsigned IW    = $clog2(NSPARE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [TW-1:0] wr_tag,
    input  logic [TW-1:0] fail_tag,
    input  logic [TW-1:0] lk_tag,
    output logic          fail_hit_c,
    output logic          lk_hit_c,
`ifdef BISR_PARITY_EN
    output logic          lk_par_err_c,
`endif
    output logic [IW-1:0] lk_idx_c
);

    logic [NSPARE-1:0][TW-1:0] tags;
    logic [NSPARE-1:0]         vld;
`ifdef BISR_PARITY_EN
    logic [NSPARE-1:0]         par;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tags <= '0;
            vld  <= '0;
`ifdef BISR_PARITY_EN
            par  <= '0;
`endif
        end else if (clr) begin
            vld <= '0;
        end else if (wr_en) begin
            tags[wr_idx] <= wr_tag;
            vld[wr_idx]  <= 1'b1;
`ifdef BISR_PARITY_EN
            par[wr_idx]  <= ^wr_tag;
`endif
        end
    end

    // Descending scan so the lowest matching index is the last one assigned.
    always_comb begin
        fail_hit_c = 1'b0;
        lk_hit_c   = 1'b0;
        lk_idx_c   = '0;
`ifdef BISR_PARITY_EN
        lk_par_err_c = 1'b0;
`endif
        for (int i = int'(NSPARE) - 1; i >= 0; i--) begin
            if (vld[i] && (tags[i] == fail_tag)) begin
                fail_hit_c = 1'b1;
            end
            if (vld[i] && (tags[i] == lk_tag)) begin
                lk_hit_c = 1'b1;
                lk_idx_c = IW'(i);
`ifdef BISR_PARITY_EN
                lk_par_err_c = (^tags[i]) != par[i];
`endif
            end
        end
    end

endmodule

// File: rtl/bisr_remap_reg.sv
// BISR remap register: captures BIST fail blocks into spare entries and redirects accesses.
// Optional BISR_PARITY_EN: per-entry parity with sticky ENTRY_ERR output.
module bisr_remap_reg
    import bisr_pkg::*;
#(
    parameter int unsigned AW      = AW_DEF,
    parameter int unsigned BLK_LSB = BLK_LSB_DEF,
    parameter int unsigned NSPARE  = NSPARE_DEF,
    localparam int unsigned IW     = $clog2(NSPARE),
    localparam int unsigned CW     = IW + 1
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          BIST_EN,
    input  logic          FAIL_VALID,
    input  logic [AW-1:0] FAIL_ADDR,
    input  logic          ACC_VALID,
    input  logic [AW-1:0] ADDR_IN,
    output logic [AW-1:0] ADDR_OUT,
    output logic          REMAP_HIT,
    output logic [IW-1:0] SPARE_SEL,
    output logic [CW-1:0] ENTRY_CNT,
    output logic          REPAIR_FAIL,
`ifdef BISR_PARITY_EN
    output logic          ENTRY_ERR,
`endif
    output logic          BUSY
);

    localparam int unsigned TW = tag_w(AW, BLK_LSB);

    state_t        state;
    logic          bist_en_d;
    logic [TW-1:0] fail_tag;
    logic [TW-1:0] lk_tag;
    logic [TW-1:0] last_tag;
    logic          last_vld;
    logic          start;
    logic          dup;
    logic          cap_new;
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic          fail_hit;
    logic          lk_hit;
    logic [IW-1:0] lk_idx;
    logic          lk_par_err;
    logic          unused_fail_lsb;

    assign fail_tag        = FAIL_ADDR[AW-1:BLK_LSB];
    assign lk_tag          = ADDR_IN[AW-1:BLK_LSB];
    assign unused_fail_lsb = ^FAIL_ADDR[BLK_LSB-1:0];

    bisr_cam #(.TW(TW), .NSPARE(NSPARE)) u_cam (
        .clk        (CLK),
        .rst_n      (RSTN),
        .clr        (start),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_tag     (fail_tag),
        .fail_tag   (fail_tag),
        .lk_tag     (lk_tag),
        .fail_hit_c (fail_hit),
        .lk_hit_c   (lk_hit),
`ifdef BISR_PARITY_EN
        .lk_par_err_c (lk_par_err),
`endif
        .lk_idx_c   (lk_idx)
    );

`ifndef BISR_PARITY_EN
    assign lk_par_err = 1'b0;
`endif

    // Session start, dedupe (CAM plus last-written bypass) and allocation decode.
    always_comb begin
        start   = (state != COLLECT) && BIST_EN && !bist_en_d;
        dup     = fail_hit || (last_vld && (last_tag == fail_tag));
        cap_new = FAIL_VALID && (state == COLLECT) && !dup;
        wr_en   = cap_new && (ENTRY_CNT < CW'(NSPARE));
        wr_idx  = ENTRY_CNT[IW-1:0];
    end

    // bist_en_d resets high so a BIST_EN held across reset release is not an edge.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state       <= IDLE;
            bist_en_d   <= 1'b1;
            BUSY        <= 1'b0;
            ENTRY_CNT   <= '0;
            REPAIR_FAIL <= 1'b0;
            last_vld    <= 1'b0;
            last_tag    <= '0;
            REMAP_HIT   <= 1'b0;
            SPARE_SEL   <= '0;
            ADDR_OUT    <= '0;
`ifdef BISR_PARITY_EN
            ENTRY_ERR   <= 1'b0;
`endif
        end else begin
            bist_en_d <= BIST_EN;
            case (state)
                IDLE, LOCKED: begin
                    if (start) begin
                        state <= COLLECT;
                        BUSY  <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (!BIST_EN) begin
                        state <= LOCKED;
                        BUSY  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase

            if (start) begin
                ENTRY_CNT   <= '0;
                REPAIR_FAIL <= 1'b0;
                last_vld    <= 1'b0;
            end else if (wr_en) begin
                ENTRY_CNT <= ENTRY_CNT + CW'(1);
                last_vld  <= 1'b1;
                last_tag  <= fail_tag;
            end else if (cap_new) begin
                REPAIR_FAIL <= 1'b1;
            end

            if (ACC_VALID) begin
                ADDR_OUT  <= ADDR_IN;
                REMAP_HIT <= lk_hit && !lk_par_err;
                SPARE_SEL <= lk_idx;
            end else begin
                REMAP_HIT <= 1'b0;
            end

`ifdef BISR_PARITY_EN
            if (start) begin
                ENTRY_ERR <= 1'b0;
            end else if (ACC_VALID && lk_hit && lk_par_err) begin
                ENTRY_ERR <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_bisr_remap_reg.sv
// Directed self-checking bench for bisr_remap_reg (default parameters).
module tb_bisr_remap_reg;

    logic        CLK;
    logic        RSTN;
    logic        BIST_EN;
    logic        FAIL_VALID;
    logic [15:0] FAIL_ADDR;
    logic        ACC_VALID;
    logic [15:0] ADDR_IN;
    logic [15:0] ADDR_OUT;
    logic        REMAP_HIT;
    logic [1:0]  SPARE_SEL;
    logic [2:0]  ENTRY_CNT;
    logic        REPAIR_FAIL;
    logic        BUSY;
`ifdef BISR_PARITY_EN
    logic        ENTRY_ERR;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    bisr_remap_reg dut (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .BIST_EN     (BIST_EN),
        .FAIL_VALID  (FAIL_VALID),
        .FAIL_ADDR   (FAIL_ADDR),
        .ACC_VALID   (ACC_VALID),
        .ADDR_IN     (ADDR_IN),
        .ADDR_OUT    (ADDR_OUT),
        .REMAP_HIT   (REMAP_HIT),
        .SPARE_SEL   (SPARE_SEL),
        .ENTRY_CNT   (ENTRY_CNT),
        .REPAIR_FAIL (REPAIR_FAIL),
`ifdef BISR_PARITY_EN
        .ENTRY_ERR   (ENTRY_ERR),
`endif
        .BUSY        (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic fail_at(input logic [15:0] a);
        FAIL_VALID = 1'b1;
        FAIL_ADDR  = a;
        step();
        FAIL_VALID = 1'b0;
    endtask

    task automatic lookup(input logic [15:0] a);
        ACC_VALID = 1'b1;
        ADDR_IN   = a;
        step();
        ACC_VALID = 1'b0;
    endtask

    initial begin
        RSTN = 1'b0; BIST_EN = 1'b0; FAIL_VALID = 1'b0; FAIL_ADDR = '0;
        ACC_VALID = 1'b0; ADDR_IN = '0;
        #3;
        check_eq("rst_cnt", 32'(ENTRY_CNT), 32'd0);
        check_eq("rst_hit", 32'(REMAP_HIT), 32'd0);
        check_eq("rst_busy", 32'(BUSY), 32'd0);
        check_eq("rst_addr", 32'(ADDR_OUT), 32'd0);
        repeat (2) step();
        RSTN = 1'b1;
        step();

        // Single capture then redirected lookup.
        BIST_EN = 1'b1; step();
        check_eq("s1_busy", 32'(BUSY), 32'd1);
        check_eq("s1_cnt0", 32'(ENTRY_CNT), 32'd0);
        fail_at(16'h0123);
        check_eq("s1_cnt1", 32'(ENTRY_CNT), 32'd1);
        BIST_EN = 1'b0; step();
        check_eq("s1_lock_busy", 32'(BUSY), 32'd0);
        lookup(16'h0130);
        check_eq("s1_miss_hit", 32'(REMAP_HIT), 32'd0);
        check_eq("s1_miss_addr", 32'(ADDR_OUT), 32'h0130);
        lookup(16'h012F);
        check_eq("s1_hit", 32'(REMAP_HIT), 32'd1);
        check_eq("s1_sel", 32'(SPARE_SEL), 32'd0);
        check_eq("s1_addr", 32'(ADDR_OUT), 32'h012F);
        step();
        check_eq("s1_idle_hit", 32'(REMAP_HIT), 32'd0);
        check_eq("s1_idle_addr", 32'(ADDR_OUT), 32'h012F);

        // Back-to-back duplicates of one block.
        BIST_EN = 1'b1; step();
        check_eq("s2_clr_cnt", 32'(ENTRY_CNT), 32'd0);
        FAIL_VALID = 1'b1;
        FAIL_ADDR = 16'h0040; step();
        FAIL_ADDR = 16'h0045; step();
        FAIL_ADDR = 16'h0040; step();
        FAIL_VALID = 1'b0;
        check_eq("s2_dedupe_cnt", 32'(ENTRY_CNT), 32'd1);
        check_eq("s2_rf", 32'(REPAIR_FAIL), 32'd0);
        lookup(16'h0047);
        check_eq("s2_collect_hit", 32'(REMAP_HIT), 32'd1);
        lookup(16'h012F);
        check_eq("s2_old_gone", 32'(REMAP_HIT), 32'd0);
        BIST_EN = 1'b0; step();

        // Overflow: five distinct tags into four spares.
        BIST_EN = 1'b1; step();
        FAIL_VALID = 1'b1;
        for (int t = 1; t <= 5; t++) begin
            FAIL_ADDR = 16'(t << 4);
            step();
            if (t == 4) check_eq("s3_rf_at4", 32'(REPAIR_FAIL), 32'd0);
        end
        FAIL_VALID = 1'b0;
        check_eq("s3_cnt_sat", 32'(ENTRY_CNT), 32'd4);
        check_eq("s3_rf", 32'(REPAIR_FAIL), 32'd1);
        BIST_EN = 1'b0; step();
        lookup(16'h0050);
        check_eq("s3_tag5_miss", 32'(REMAP_HIT), 32'd0);
        lookup(16'h0040);
        check_eq("s3_tag4_hit", 32'(REMAP_HIT), 32'd1);
        check_eq("s3_tag4_sel", 32'(SPARE_SEL), 32'd3);
        lookup(16'h001A);
        check_eq("s3_tag1_sel", 32'(SPARE_SEL), 32'd0);
        check_eq("s3_rf_sticky", 32'(REPAIR_FAIL), 32'd1);

        // Two entries, lock, then a fresh session clears them.
        BIST_EN = 1'b1; step();
        check_eq("s4_rf_clr", 32'(REPAIR_FAIL), 32'd0);
        fail_at(16'h0A00);
        fail_at(16'h0B00);
        BIST_EN = 1'b0; step();
        check_eq("s4_cnt", 32'(ENTRY_CNT), 32'd2);
        lookup(16'h0B05);
        check_eq("s4_sel", 32'(SPARE_SEL), 32'd1);
        check_eq("s4_hit", 32'(REMAP_HIT), 32'd1);
        BIST_EN = 1'b1; step();
        check_eq("s4_new_cnt", 32'(ENTRY_CNT), 32'd0);
        check_eq("s4_new_busy", 32'(BUSY), 32'd1);
        lookup(16'h0A00);
        check_eq("s4_old_miss", 32'(REMAP_HIT), 32'd0);

        // Async reset mid-session after three captures.
        fail_at(16'h1000);
        fail_at(16'h2000);
        fail_at(16'h3000);
        check_eq("s5_cnt3", 32'(ENTRY_CNT), 32'd3);
        lookup(16'h2003);
        check_eq("s5_hit", 32'(REMAP_HIT), 32'd1);
        check_eq("s5_sel", 32'(SPARE_SEL), 32'd1);
        #2 RSTN = 1'b0;
        #1;
        check_eq("s5_rst_cnt", 32'(ENTRY_CNT), 32'd0);
        check_eq("s5_rst_hit", 32'(REMAP_HIT), 32'd0);
        check_eq("s5_rst_sel", 32'(SPARE_SEL), 32'd0);
        check_eq("s5_rst_addr", 32'(ADDR_OUT), 32'd0);
        check_eq("s5_rst_busy", 32'(BUSY), 32'd0);
        step();
        RSTN = 1'b1;
        FAIL_VALID = 1'b1; FAIL_ADDR = 16'h4000;
        repeat (3) step();
        FAIL_VALID = 1'b0;
        check_eq("s5_held_en_cnt", 32'(ENTRY_CNT), 32'd0);
        check_eq("s5_held_en_busy", 32'(BUSY), 32'd0);
        BIST_EN = 1'b0; step();
        BIST_EN = 1'b1; step();
        check_eq("s5_edge_busy", 32'(BUSY), 32'd1);
        BIST_EN = 1'b0; step();

`ifdef BISR_PARITY_EN
        // Corrupt entry 0 tag bit 0 and look up the corrupted tag.
        BIST_EN = 1'b1; step();
        fail_at(16'h0120);
        BIST_EN = 1'b0; step();
        force dut.u_cam.tags = {36'h0, 12'h013};
        lookup(16'h0130);
        check_eq("par_hit", 32'(REMAP_HIT), 32'd0);
        check_eq("par_err", 32'(ENTRY_ERR), 32'd1);
        release dut.u_cam.tags;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bisr_remap_reg.md
Name: bisr_remap_reg

Overview:
- Built-in self-repair remap register. It sits between the BIST FSM and the memory array in MEMCTRL.
- During a BIST run it captures failing block addresses reported by the BIST FSM and allocates one spare block per distinct failing block.
- In normal mode it compares every access address against the stored entries. On a hit it redirects the access to the matching spare block.

Parameters:
- AW, 16, address width.
- BLK_LSB, 4, low address bits inside a block. Compare and tag use ADDR[AW-1:BLK_LSB].
- NSPARE, 4, number of spare blocks / remap entries (power of 2, >=2).

Ports:
- CLK  in  1  system clock, rising edge.
- RSTN  in  1  asynchronous active-low reset.
- BIST_EN  in  1  BIST session active; a rising edge starts a new capture session.
- FAIL_VALID  in  1  one-cycle pulse from BIST FSM: miscompare at FAIL_ADDR.
- FAIL_ADDR  in  AW  failing address.
- ACC_VALID  in  1  normal-mode access strobe (CE & ~CSB).
- ADDR_IN  in  AW  normal-mode access address.
- ADDR_OUT  out  AW  registered passthrough of ADDR_IN.
- REMAP_HIT  out  1  registered; access targets a repaired block.
- SPARE_SEL  out  log2(NSPARE)  registered spare index, valid when REMAP_HIT=1.
- ENTRY_CNT  out  log2(NSPARE)+1  number of allocated entries.
- REPAIR_FAIL  out  1  sticky; a distinct fail arrived with all entries used.
- BUSY  out  1  high in COLLECT state.

Behaviour:
- Reset (async, RSTN=0):
  - All entry valid bits = 0; ENTRY_CNT=0; REPAIR_FAIL=0; REMAP_HIT=0; SPARE_SEL=0; ADDR_OUT=0; BUSY=0.
  - State = IDLE.
  - Reset in the middle of COLLECT discards everything captured so far.
- FSM states: IDLE, COLLECT, LOCKED.
  - IDLE -> COLLECT on BIST_EN rising edge (BIST_EN=1, registered BIST_EN_d=0). On entry, clear all valid bits, ENTRY_CNT and REPAIR_FAIL in the same clock.
  - COLLECT -> LOCKED when BIST_EN=0.
  - LOCKED -> COLLECT on the next BIST_EN rising edge, with the same clear.
  - A BIST_EN that is already high when reset releases does not start a session; a low-to-high edge is required.
- Capture (COLLECT only; FAIL_VALID is ignored in IDLE and LOCKED):
  - Tag = FAIL_ADDR[AW-1:BLK_LSB].
  - If the tag matches a valid entry: no change (dedupe).
  - Otherwise, if ENTRY_CNT<NSPARE: write entry[ENTRY_CNT] = tag, set its valid bit, ENTRY_CNT+1 on the next edge.
  - Otherwise set REPAIR_FAIL=1 (sticky until the next session clear or reset).
  - Back-to-back FAIL_VALID pulses are accepted every cycle. Dedupe compares against entries valid before the current edge, so a repeat tag in consecutive cycles must also be caught: compare against the entry being written in the same cycle via a bypass on the last-written tag.
- Lookup (any state, including COLLECT):
  - Combinational compare of ADDR_IN[AW-1:BLK_LSB] against all valid entries. The result is registered when ACC_VALID=1.
  - Latency: 1 clock, covering ADDR_OUT, REMAP_HIT and SPARE_SEL.
  - ACC_VALID=0: REMAP_HIT goes to 0; ADDR_OUT and SPARE_SEL hold.
  - Multiple matches cannot occur by construction; if they do, the lowest index wins.
  - In COLLECT, lookup uses the entries as they stand, so BIST read-back after repair is not yet redirected. This is intended: BIST tests the raw array.
- Entry index i maps 1:1 to spare block i. ENTRY_CNT saturates at NSPARE.

Optional Feature:
- Macro BISR_PARITY_EN.
- Defined:
  - Each entry stores an even-parity bit computed on write.
  - Lookup recomputes parity on the matching entry. A mismatch suppresses REMAP_HIT and sets the extra output ENTRY_ERR (1 bit, sticky, cleared by session clear or reset).
- Undefined: no parity storage; the ENTRY_ERR port is absent.

Decomposition:
- Package bisr_pkg:
  - State enum typedef (IDLE/COLLECT/LOCKED).
  - Default AW/BLK_LSB/NSPARE constants.
  - Tag width function AW-BLK_LSB.
- Sub-module bisr_cam: entry storage, valid bits, parallel compare and priority encoder, instantiated once.
- The top holds the FSM, the capture/allocation logic and the output registers.

Test Plan:
- Reset, pulse BIST_EN, FAIL_VALID with FAIL_ADDR=16'h0123 -> ENTRY_CNT=1. Then drop BIST_EN, ACC_VALID with ADDR_IN=16'h012F -> next cycle REMAP_HIT=1, SPARE_SEL=0, ADDR_OUT=16'h012F.
- In COLLECT, fails at 16'h0040, then 16'h0045, then 16'h0040 on consecutive cycles -> ENTRY_CNT=1 (same block tag 0x004), REPAIR_FAIL=0.
- Five distinct fails (tags 1..5) with NSPARE=4 -> ENTRY_CNT=4, REPAIR_FAIL=1. Lookup of tag 5 -> REMAP_HIT=0; lookup of tag 4 -> SPARE_SEL=3.
- After LOCKED with 2 entries, a new BIST_EN rising edge -> ENTRY_CNT=0, REPAIR_FAIL=0, previous addresses no longer hit.
- Assert RSTN=0 mid-COLLECT after 3 captures -> all outputs 0 immediately, without a clock edge. FAIL_VALID in IDLE after release -> ENTRY_CNT stays 0.
- With BISR_PARITY_EN: force-corrupt bit 0 of entry 0 tag, then look it up -> REMAP_HIT=0, ENTRY_ERR=1.
